// File: rtl/accu_group4_if.sv
// accu_group4_if: streaming bus between a valid-only producer, the group
// accumulator and its downstream consumer.
//   data_in   : sample from the producer, qualified by valid_in
//   valid_in  : data_in is valid this cycle (no backpressure)
//   valid_out : one-cycle pulse, data_out holds a completed group sum
//   data_out  : registered group sum
// Modports:
//   master : producer/consumer side (drives inputs, observes outputs)
//   slave  : accumulator side
interface accu_group4_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 10
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              valid_out;
    logic [OUT_W-1:0]  data_out;

    modport master (
        output data_in,
        output valid_in,
        input  valid_out,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output valid_out,
        output data_out
    );
endinterface : accu_group4_if

// File: rtl/accu_group4.sv
// accu_group4: sums consecutive groups of GROUP accepted samples and emits
// each total with a one-cycle valid_out pulse. Every valid_in beat is
// consumed; idle cycles inside a group are allowed and simply hold state.
// Arithmetic is unsigned modulo 2^OUT_W.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : accu_group4_if.slave (data_in, valid_in, valid_out, data_out)
// Parameters:
//   DATA_W : sample width
//   GROUP  : samples per sum, must be >= 2
//   OUT_W  : sum width
module accu_group4 #(
    parameter int DATA_W = 8,
    parameter int GROUP  = 4,
    parameter int OUT_W  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    accu_group4_if.slave   bus
);
    localparam int CNT_W = (GROUP > 2) ? $clog2(GROUP) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(GROUP - 1);

    logic [CNT_W-1:0] beat_cnt;
    logic [OUT_W-1:0] part_sum;
    logic [OUT_W-1:0] sum_next;
    logic [OUT_W-1:0] data_q;
    logic             valid_q;
    logic             last_beat;

    // Zero-extend the sample and add it to the running partial sum.
    assign sum_next  = part_sum + OUT_W'(bus.data_in);
    assign last_beat = (beat_cnt == LAST_BEAT);

    // NOTE: all state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers; blocking here would let
    // part_sum see its own updated value within the same edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // NOTE: reset is synchronous and active high; it clears the
            // output registers too, so a group completing on the reset
            // edge never produces a pulse.
            beat_cnt <= '0;
            part_sum <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            // Default: the pulse lasts a single cycle.
            valid_q <= 1'b0;
            if (bus.valid_in) begin
                if (last_beat) begin
                    data_q   <= sum_next;
                    valid_q  <= 1'b1;
                    beat_cnt <= '0;
                    part_sum <= '0;
                end else begin
                    part_sum <= sum_next;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
endmodule : accu_group4

// File: tb/tb_accu_group4.sv
// tb_accu_group4: directed stimulus with hand-computed group sums. The
// driver pushes each expected sum, tagged with the cycle its pulse is due,
// into a scoreboard queue; a separate monitor pops and compares whenever
// the DUT presents valid_out, and flags pulses that are late or unexpected.
module tb_accu_group4;
    localparam int DATA_W = 8;
    localparam int GROUP  = 4;
    localparam int OUT_W  = 10;

    typedef struct {
        logic [OUT_W-1:0] sum;
        int               due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   n_pulse;
    exp_t sb[$];

    accu_group4_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    accu_group4 #(.DATA_W(DATA_W), .GROUP(GROUP), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply the current inputs across one rising edge; return #1 after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        step();
    endtask

    // Last beat of a group: the pulse is due in the cycle after this edge.
    task automatic beat_last(input logic [DATA_W-1:0] d, input int sum);
        exp_t e;
        e.sum = OUT_W'(sum);
        e.due = cyc + 1;
        sb.push_back(e);
        beat(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.valid_in = 1'b0;
            bus.data_in  = 8'hA5;   // junk, must be ignored
            step();
        end
    endtask

    // Monitor: sample at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.valid_out) begin
            n_pulse++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", bus.valid_out, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("group_sum", bus.data_out, e.sum);
                check("pulse_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("valid_out_when_due", bus.valid_out, 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        n_pulse = 0;
        rst_n        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        step();
        step();
        check("reset_valid_out", bus.valid_out, 0);
        check("reset_data_out", bus.data_out, 0);
        rst_n = 1'b0;

        // Idle only: nothing may come out.
        idle(6);
        check("idle_data_out", bus.data_out, 0);
        check("idle_valid_out", bus.valid_out, 0);

        // Continuous stream of three groups: 20, 114, 68.
        beat(8'd1); beat(8'd2); beat(8'd3); beat_last(8'd14, 20);
        beat(8'd5); beat(8'd2); beat(8'd103); beat_last(8'd4, 114);
        beat(8'd5); beat(8'd6); beat(8'd3); beat_last(8'd54, 68);
        idle(1);

        // Maximum samples: 4*255 fits exactly in 10 bits.
        beat(8'd255); beat(8'd255); beat(8'd255); beat_last(8'd255, 1020);
        idle(3);
        check("hold_data_out", bus.data_out, 1020);
        check("hold_valid_out", bus.valid_out, 0);

        // Gaps inside a group.
        beat(8'd10); idle(3); beat(8'd20); idle(1); beat(8'd30); beat_last(8'd40, 100);
        idle(2);

        // Reset mid-group discards 7+8.
        beat(8'd7); beat(8'd8);
        rst_n = 1'b1;
        idle(1);
        check("midreset_valid_out", bus.valid_out, 0);
        check("midreset_data_out", bus.data_out, 0);
        rst_n = 1'b0;
        idle(1);
        check("postreset_valid_out", bus.valid_out, 0);
        beat(8'd1); beat(8'd1); beat(8'd1); beat_last(8'd1, 4);
        idle(2);

        // Reset on the completing edge wins.
        beat(8'd1); beat(8'd2); beat(8'd3);
        rst_n = 1'b1;
        beat(8'd4);
        check("rst_on_last_valid_out", bus.valid_out, 0);
        check("rst_on_last_data_out", bus.data_out, 0);
        rst_n = 1'b0;
        idle(1);
        check("rst_on_last_after", bus.valid_out, 0);

        // Fresh group after that reset.
        beat(8'd9); beat(8'd9); beat(8'd9); beat_last(8'd9, 36);
        idle(6);

        check("scoreboard_drained", sb.size(), 0);
        check("pulse_count", n_pulse, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_accu_group4

// File: doc/accu_group4.md
Name: accu_group4

Overview:
- Streaming accumulator that sums consecutive groups of GROUP valid input samples.
- Emits each group total with a one-cycle valid_out pulse.
- Sits between a valid-only, non-backpressured producer and a downstream consumer that samples on valid_out.
- No ready signal; every valid_in beat is consumed.

Parameters:
- DATA_W, 8, input sample width.
- GROUP, 4, number of valid samples per sum; must be >= 2.
- OUT_W, 10, sum width; default holds GROUP*(2^DATA_W-1) = 1020 without overflow.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on rising clk; the name is kept for codebase consistency).
- data_in  input  DATA_W  sample, unsigned, qualified by valid_in.
- valid_in  input  1  data_in is valid this cycle; sampled on rising clk.
- valid_out  output  1  one-cycle pulse: data_out holds a completed group sum.
- data_out  output  OUT_W  unsigned group sum, registered.

Behaviour:
- Reset, rst_n=1 at a rising edge:
  - valid_out=0, data_out=0.
  - Beat counter=0, partial sum=0.
  - Reset takes priority over all other activity.
- Accepting a beat (valid_in=1 at a rising edge):
  - Beat accepted and zero-extended to OUT_W.
  - Added to the partial sum; counter increments.
- Idle edges (valid_in=0): counter and partial sum hold. Gaps of any length are allowed inside a group.
- Group completion (the edge that accepts beat number GROUP):
  - data_out <= partial sum + data_in.
  - valid_out <= 1.
  - Counter and partial sum return to 0.
- Latency: valid_out and data_out are high/valid in the clock cycle immediately after the edge that accepted the last beat of a group.
- valid_out is high for exactly one cycle per group; it drops at the next edge unless that edge also completes a group.
- data_out holds the last completed sum until the next group completes. It is only meaningful while valid_out=1.
- Back-to-back streaming:
  - The first beat of the next group may arrive on the cycle valid_out is high; no bubble.
  - A continuous valid_in stream yields one pulse every GROUP cycles.
- Arithmetic: unsigned modulo 2^OUT_W. It wraps silently if the parameters allow overflow; there is no saturation flag.
- Reset mid-group: the partial group is discarded. The next accepted beat starts a fresh group.
- Reset on the edge where a group would complete: reset wins, so valid_out=0 and data_out=0.
- data_in is ignored whenever valid_in=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset release then continuous valid_in with 1,2,3,14 → exactly one valid_out pulse one cycle after the 4th beat, data_out=20.
- Continue stream without gap with 5,2,103,4 then 5,6,3,54 → pulses with data_out=114 then 68, spaced exactly 4 cycles apart, 3 pulses total over 12 beats.
- Max values: 255,255,255,255 → data_out=1020; no wrap at the default width.
- Gaps: 10, idle 3 cycles, 20, idle, 30, 40 → single pulse data_out=100, one cycle after the 40 beat; no pulse during the gaps.
- Reset mid-group: 7,8, then assert rst_n one cycle, then 1,1,1,1 → data_out=4 (not 19); valid_out=0 during and right after reset.
- Idle-only input after reset → valid_out stays 0 and data_out stays 0 indefinitely.
